// File: rtl/ad9361_ctrl_out_monitor.sv
// AD9361 CTRL_OUT receive monitor: synchronize, glitch-filter, detect masked changes and
// queue {timestamp, status} events in a first-word-fall-through FIFO.
module ad9361_ctrl_out_monitor #(
    parameter int unsigned STATUS_WIDTH    = 8,
    parameter int unsigned TS_WIDTH        = 24,
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned STABLE_CYCLES   = 2
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic [STATUS_WIDTH-1:0]      ctrl_out_in,
    input  logic                         mon_enable,
    input  logic                         mon_clear,
    input  logic [STATUS_WIDTH-1:0]      mon_mask,
    output logic [STATUS_WIDTH-1:0]      status_filt,
    output logic                         rd_valid,
    output logic [TS_WIDTH+STATUS_WIDTH-1:0] rd_data,
    input  logic                         rd_ready,
    output logic [FIFO_ADDR_WIDTH:0]     fifo_level,
    output logic                         overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned DW    = TS_WIDTH + STATUS_WIDTH;
    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]         CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] LEVEL_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    logic [STATUS_WIDTH-1:0]    sync1_q, sync_q, cand_q, status_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [TS_WIDTH-1:0]        ts_q;
    logic [DW-1:0]              mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   level_q, level_d;
    logic                       overflow_q;
    logic                       update, evt, full, pop, do_push, ovf_set;

    assign update  = (cand_q == sync_q) && (cnt_q == CNT_MAX) && (cand_q != status_q);
    assign evt     = update && mon_enable && (|((cand_q ^ status_q) & mon_mask));
    assign full    = (level_q == LEVEL_FULL);
    assign pop     = rd_ready && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
    assign do_push = evt && (!full || pop);
    assign ovf_set = evt && full && !pop;

    always_comb begin
        level_d = level_q;
        if (do_push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            sync1_q <= ctrl_out_in;
            sync_q  <= sync1_q;
            if (sync_q != cand_q) begin
                cand_q <= sync_q;
                cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (update) begin
                status_q <= cand_q;
            end
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            ts_q <= '0;
        end else if (mon_clear) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (mon_clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {ts_q, cand_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign status_filt = status_q;
    assign rd_valid    = (level_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ad9361_ctrl_out_monitor.sv
// Directed bench for ad9361_ctrl_out_monitor with a queue of expected FIFO entries.
module tb_ad9361_ctrl_out_monitor;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic [7:0]  ctrl_out_in, c4;
    logic        mon_enable, mon_clear, rd_ready, rd4;
    logic [7:0]  mon_mask;
    logic [7:0]  status_filt, s4;
    logic        rd_valid, overflow, v4, o4;
    logic [31:0] rd_data;
    logic [11:0] d4;
    logic [4:0]  fifo_level, l4;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [23:0] tsm;

    always #5 up_clk = ~up_clk;

    ad9361_ctrl_out_monitor dut (
        .up_clk(up_clk), .up_rstn(up_rstn), .ctrl_out_in(ctrl_out_in),
        .mon_enable(mon_enable), .mon_clear(mon_clear), .mon_mask(mon_mask),
        .status_filt(status_filt), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ready(rd_ready), .fifo_level(fifo_level), .overflow(overflow)
    );

    ad9361_ctrl_out_monitor #(.TS_WIDTH(4)) dut4 (
        .up_clk(up_clk), .up_rstn(up_rstn), .ctrl_out_in(c4),
        .mon_enable(mon_enable), .mon_clear(mon_clear), .mon_mask(mon_mask),
        .status_filt(s4), .rd_valid(v4), .rd_data(d4),
        .rd_ready(rd4), .fifo_level(l4), .overflow(o4)
    );

    // Reference timestamp: free-running, zeroed by reset and mon_clear.
    always @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) tsm <= '0;
        else if (mon_clear) tsm <= '0;
        else tsm <= tsm + 24'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a held value; an accepted change is stamped 4 edges after the capturing edge.
    task automatic drive_evt(input logic [7:0] val, input bit expect_entry);
        ctrl_out_in = val;
        if (expect_entry) exp_q.push_back({tsm + 24'd4, val});
        repeat (6) @(negedge up_clk);
    endtask

    task automatic read_one(input string tag);
        logic [31:0] e;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 64'(rd_data), 64'(e));
        end
        rd_ready = 1'b1;
        @(negedge up_clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] e_new;
        logic [3:0]  ts_a, ts_b;
        up_rstn = 1'b0; ctrl_out_in = 8'h00; c4 = 8'h00;
        mon_enable = 1'b1; mon_clear = 1'b0; mon_mask = 8'hFF; rd_ready = 1'b0; rd4 = 1'b0;
        repeat (3) @(negedge up_clk);
        check("rst_status", 64'(status_filt), 64'h0);
        check("rst_valid", 64'(rd_valid), 64'h0);
        check("rst_data", 64'(rd_data), 64'h0);
        check("rst_level", 64'(fifo_level), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);

        // 1: first change after reset, latency to rd_valid
        up_rstn = 1'b1;
        ctrl_out_in = 8'h5A;
        exp_q.push_back({tsm + 24'd4, 8'h5A});
        repeat (4) @(negedge up_clk);
        check("lat_edge4_valid", 64'(rd_valid), 64'h0);
        @(negedge up_clk);
        check("lat_edge5_valid", 64'(rd_valid), 64'h1);
        check("t1_status", 64'(status_filt), 64'h5A);
        read_one("t1");

        // 2: single-cycle glitch is filtered
        ctrl_out_in = 8'h81;
        @(negedge up_clk);
        ctrl_out_in = 8'h5A;
        repeat (8) @(negedge up_clk);
        check("glitch_level", 64'(fifo_level), 64'h0);
        check("glitch_status", 64'(status_filt), 64'h5A);

        // 3: masked bit updates status only; unmasked change queues both
        mon_mask = 8'h0F;
        drive_evt(8'hDA, 1'b0);
        check("mask_level", 64'(fifo_level), 64'h0);
        check("mask_status", 64'(status_filt), 64'hDA);
        drive_evt(8'hDB, 1'b1);
        read_one("mask_evt");
        mon_mask = 8'hFF;

        // 4: overflow, then pop concurrent with an event while full
        for (int i = 0; i < 17; i++) drive_evt(8'h10 + 8'(i), i < 16);
        check("full_level", 64'(fifo_level), 64'd16);
        check("full_ovf", 64'(overflow), 64'h1);
        ctrl_out_in = 8'h30;
        e_new = {tsm + 24'd4, 8'h30};
        repeat (4) @(negedge up_clk);
        begin
            logic [31:0] head;
            head = exp_q.pop_front();
            check("full_pop_head", 64'(rd_data), 64'(head));
        end
        rd_ready = 1'b1;
        @(negedge up_clk);
        rd_ready = 1'b0;
        exp_q.push_back(e_new);
        check("full_pushpop_level", 64'(fifo_level), 64'd16);
        repeat (2) @(negedge up_clk);
        for (int i = 0; i < 16; i++) read_one($sformatf("drain%0d", i));
        check("drain_level", 64'(fifo_level), 64'h0);
        rd_ready = 1'b1;
        @(negedge up_clk);
        rd_ready = 1'b0;
        check("underflow_level", 64'(fifo_level), 64'h0);

        // disabled changes update status only, no catch-up on re-enable
        mon_enable = 1'b0;
        drive_evt(8'h55, 1'b0);
        check("dis_status", 64'(status_filt), 64'h55);
        mon_enable = 1'b1;
        repeat (6) @(negedge up_clk);
        check("reen_level", 64'(fifo_level), 64'h0);

        // 5: clear beats concurrent event and pop
        drive_evt(8'h40, 1'b1);
        drive_evt(8'h41, 1'b1);
        drive_evt(8'h42, 1'b1);
        check("pre_clr_level", 64'(fifo_level), 64'd3);
        check("pre_clr_ovf", 64'(overflow), 64'h1);
        ctrl_out_in = 8'h43;
        repeat (4) @(negedge up_clk);
        mon_clear = 1'b1; rd_ready = 1'b1;
        @(negedge up_clk);
        mon_clear = 1'b0; rd_ready = 1'b0;
        exp_q.delete();
        check("clr_level", 64'(fifo_level), 64'h0);
        check("clr_valid", 64'(rd_valid), 64'h0);
        check("clr_ovf", 64'(overflow), 64'h0);
        check("clr_status", 64'(status_filt), 64'h43);
        drive_evt(8'h44, 1'b1);
        read_one("post_clr");

        // 6: 4-bit timestamp wraps; 20 cycles apart -> delta 4
        c4 = 8'h11;
        repeat (20) @(negedge up_clk);
        c4 = 8'h22;
        repeat (6) @(negedge up_clk);
        check("ts4_level", 64'(l4), 64'd2);
        check("ts4_st1", 64'(d4[7:0]), 64'h11);
        ts_a = d4[11:8];
        rd4 = 1'b1;
        @(negedge up_clk);
        rd4 = 1'b0;
        check("ts4_st2", 64'(d4[7:0]), 64'h22);
        ts_b = d4[11:8];
        check("ts4_delta", 64'(4'(ts_b - ts_a)), 64'd4);

        // reset mid-operation drops in-flight state
        ctrl_out_in = 8'h77;
        drive_evt(8'h77, 1'b0);
        up_rstn = 1'b0;
        #1;
        check("midrst_level", 64'(fifo_level), 64'h0);
        check("midrst_status", 64'(status_filt), 64'h0);
        check("midrst_valid", 64'(rd_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
